// File: rtl/bb_pkg.sv
// Shared definitions for the baseband stream arbiter: arbiter state
// encoding, default widths and the 5.11 fixed-point sample format
// carried in each half of a data word.
package bb_pkg;

    // Default data width: Im in [31:16], Re in [15:0].
    localparam int DW_DEF    = 32;
    // Default per-frame beat counter width.
    localparam int CNT_W_DEF = 16;

    // 5.11 fixed-point sample format of each I/Q component.
    localparam int Q_INT_W   = 5;
    localparam int Q_FRAC_W  = 11;
    localparam int Q_W       = Q_INT_W + Q_FRAC_W;
    localparam int RE_LSB    = 0;
    localparam int IM_LSB    = Q_W;

    // Arbiter state encoding.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_GRANT0 = GRANT0,
        ST_GRANT1 = GRANT1,
        ST_DRAIN  = DRAIN
    } arb_state_t;

    // One-hot grant vector for a given arbiter state; 00 outside GRANTn.
    function automatic logic [1:0] grant_onehot(input arb_state_t st);
        logic [1:0] g;
        case (st)
            ST_GRANT0: g = 2'b01;
            ST_GRANT1: g = 2'b10;
            default:   g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bb_out_stage.sv
// One-entry registered output stage with STB/ACK handshake.
// A load captures data/we and raises stb; a downstream ack without a
// simultaneous load empties the stage, leaving data/we untouched.
module bb_out_stage
    import bb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_dat,
    input  logic          load_we,
    input  logic          ds_ack,
    output logic [DW-1:0] dat,
    output logic          we,
    output logic          stb,
    output logic          ready
);

    logic [DW-1:0] dat_r;
    logic          we_r;
    logic          stb_r;

    // Stage can take a new beat when empty or when its beat leaves this cycle.
    assign ready = ~stb_r | ds_ack;
    assign dat   = dat_r;
    assign we    = we_r;
    assign stb   = stb_r;

    // Capture a beat on load, otherwise retire the held beat on downstream ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_r <= '0;
            we_r  <= 1'b0;
            stb_r <= 1'b0;
        end else if (load) begin
            dat_r <= load_dat;
            we_r  <= load_we;
            stb_r <= 1'b1;
        end else if (stb_r & ds_ack) begin
            stb_r <= 1'b0;
        end else begin
            stb_r <= stb_r;
        end
    end

endmodule

// File: rtl/bb_stream_arbiter.sv
// Two-source frame arbiter in front of a single baseband stream link.
// A source owns the link for a whole CYC frame; ownership only changes
// after the frame ends and the output stage has drained.
// Build option: BB_ARB_FIXED_PRIO_EN makes source 0 win every tie in IDLE;
// without it ties alternate with the previous grant.
module bb_stream_arbiter
    import bb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [DW-1:0]    S0_DAT_I,
    input  logic             S0_WE_I,
    input  logic             S0_STB_I,
    input  logic             S0_CYC_I,
    output logic             S0_ACK_O,
    input  logic [DW-1:0]    S1_DAT_I,
    input  logic             S1_WE_I,
    input  logic             S1_STB_I,
    input  logic             S1_CYC_I,
    output logic             S1_ACK_O,
    output logic [DW-1:0]    DAT_O,
    output logic             WE_O,
    output logic             STB_O,
    output logic             CYC_O,
    input  logic             ACK_I,
    output logic [1:0]       GNT_O,
    output logic [CNT_W-1:0] BEAT_CNT_O
);

    arb_state_t       state_r;
    logic             last_grant_r;
    logic [CNT_W-1:0] beat_cnt_r;

    logic             stb_s;
    logic             ready_s;
    logic             ack0_s;
    logic             ack1_s;
    logic             load_s;
    logic [DW-1:0]    load_dat_s;
    logic             load_we_s;
    logic             tie_src_s;
    logic             beat_leaves_s;

    // Source that wins when both CYC lines are high in IDLE.
`ifdef BB_ARB_FIXED_PRIO_EN
    assign tie_src_s = 1'b0;
`else
    assign tie_src_s = ~last_grant_r;
`endif

    // ACK requires the grant, CYC and STB of that source plus room in the stage,
    // so a CYC drop always wins over a same-cycle STB.
    assign ack0_s = (state_r == ST_GRANT0) & S0_CYC_I & S0_STB_I & ready_s;
    assign ack1_s = (state_r == ST_GRANT1) & S1_CYC_I & S1_STB_I & ready_s;
    assign load_s = ack0_s | ack1_s;

    // The buffered beat is gone after this edge (or there never was one).
    assign beat_leaves_s = ~stb_s | ACK_I;

    assign S0_ACK_O   = ack0_s;
    assign S1_ACK_O   = ack1_s;
    assign GNT_O      = grant_onehot(state_r);
    assign CYC_O      = (state_r == ST_GRANT0) | (state_r == ST_GRANT1) | stb_s;
    assign STB_O      = stb_s;
    assign BEAT_CNT_O = beat_cnt_r;

    // Route the granted source's data/we into the output stage.
    always_comb begin
        load_dat_s = S0_DAT_I;
        load_we_s  = S0_WE_I;
        if (ack1_s) begin
            load_dat_s = S1_DAT_I;
            load_we_s  = S1_WE_I;
        end else begin
            load_dat_s = S0_DAT_I;
            load_we_s  = S0_WE_I;
        end
    end

    // Arbiter FSM: frame grant, release on CYC drop, drain of the buffered beat,
    // plus the per-frame saturating beat counter.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            beat_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (S0_CYC_I & S1_CYC_I) begin
                        state_r      <= tie_src_s ? ST_GRANT1 : ST_GRANT0;
                        last_grant_r <= tie_src_s;
                        beat_cnt_r   <= '0;
                    end else if (S0_CYC_I) begin
                        state_r      <= ST_GRANT0;
                        last_grant_r <= 1'b0;
                        beat_cnt_r   <= '0;
                    end else if (S1_CYC_I) begin
                        state_r      <= ST_GRANT1;
                        last_grant_r <= 1'b1;
                        beat_cnt_r   <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT0: begin
                    if (!S0_CYC_I) begin
                        state_r <= beat_leaves_s ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_r <= ST_GRANT0;
                    end
                    if (ack0_s && (beat_cnt_r != {CNT_W{1'b1}})) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                ST_GRANT1: begin
                    if (!S1_CYC_I) begin
                        state_r <= beat_leaves_s ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_r <= ST_GRANT1;
                    end
                    if (ack1_s && (beat_cnt_r != {CNT_W{1'b1}})) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                ST_DRAIN: begin
                    if (beat_leaves_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    bb_out_stage #(
        .DW (DW)
    ) u_out_stage (
        .clk      (CLK_I),
        .rst      (RST_I),
        .load     (load_s),
        .load_dat (load_dat_s),
        .load_we  (load_we_s),
        .ds_ack   (ACK_I),
        .dat      (DAT_O),
        .we       (WE_O),
        .stb      (stb_s),
        .ready    (ready_s)
    );

endmodule

// File: tb/tb_bb_stream_arbiter.sv
// Self-checking bench for bb_stream_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences (async reset, counter saturation) and a
// randomized run against a transaction-level reference model.
module tb_bb_stream_arbiter;

    localparam int DW    = 32;
    localparam int CNT_W = 16;
`ifdef BB_ARB_FIXED_PRIO_EN
    localparam logic FIXED = 1'b1;
`else
    localparam logic FIXED = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    s0_dat, s1_dat, dat_o;
    logic             s0_we, s0_stb, s0_cyc, s0_ack;
    logic             s1_we, s1_stb, s1_cyc, s1_ack;
    logic             we_o, stb_o, cyc_o, ack_i;
    logic [1:0]       gnt_o;
    logic [CNT_W-1:0] cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bb_stream_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
        .CLK_I(clk), .RST_I(rst),
        .S0_DAT_I(s0_dat), .S0_WE_I(s0_we), .S0_STB_I(s0_stb), .S0_CYC_I(s0_cyc), .S0_ACK_O(s0_ack),
        .S1_DAT_I(s1_dat), .S1_WE_I(s1_we), .S1_STB_I(s1_stb), .S1_CYC_I(s1_cyc), .S1_ACK_O(s1_ack),
        .DAT_O(dat_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o), .ACK_I(ack_i),
        .GNT_O(gnt_o), .BEAT_CNT_O(cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic s0c; logic s0s; logic [31:0] s0d;
        logic s1c; logic s1s; logic [31:0] s1d;
        logic ack;
        logic e_a0; logic e_a1; logic e_stb; logic [31:0] e_dat;
        logic [1:0] e_gnt; logic [15:0] e_cnt; logic e_cyc;
    } vec_t;

    function automatic vec_t v(input logic s0c, input logic s0s, input logic [31:0] s0d,
                               input logic s1c, input logic s1s, input logic [31:0] s1d,
                               input logic ack, input logic a0, input logic a1, input logic stb,
                               input logic [31:0] dat, input logic [1:0] gnt,
                               input logic [15:0] cnt, input logic cyc);
        vec_t r;
        r.s0c = s0c; r.s0s = s0s; r.s0d = s0d; r.s1c = s1c; r.s1s = s1s; r.s1d = s1d;
        r.ack = ack; r.e_a0 = a0; r.e_a1 = a1; r.e_stb = stb; r.e_dat = dat;
        r.e_gnt = gnt; r.e_cnt = cnt; r.e_cyc = cyc;
        return r;
    endfunction

    task automatic idle_inputs();
        s0_dat = 32'h0; s0_we = 1'b0; s0_stb = 1'b0; s0_cyc = 1'b0;
        s1_dat = 32'h0; s1_we = 1'b0; s1_stb = 1'b0; s1_cyc = 1'b0;
        ack_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[29];

    // Reference model state (transaction level): frame holder, release-wait flag,
    // a one-deep queue of buffered beats {we,dat}, last output word, beat count.
    int          m_holder;
    bit          m_waiting;
    logic [32:0] m_pend[$];
    logic [31:0] m_dat;
    logic        m_we;
    int          m_cnt;
    int          m_last;

    initial begin
        logic [31:0] b1, b2, b3, b4, da, db, dc, dd, dd2, dd3, de, z, w26;
        logic [1:0]  g26;
        rst = 1'b1;
        idle_inputs();
        b1 = 32'h0001_0800; b2 = 32'h0002_0800; b3 = 32'h0003_0800; b4 = 32'h0004_0800;
        da = 32'h1111_0001; db = 32'h2222_0002; dc = 32'h3333_0003;
        dd = 32'h0A0A_0A0A; dd2 = 32'h0A0A_0A0B; dd3 = 32'h0A0A_0A0C; de = 32'h0B0B_0B0B;
        z  = 32'h0;
        w26 = FIXED ? dd3 : de;
        g26 = FIXED ? 2'b01 : 2'b10;

        // S0-only 4-beat frame at full rate
        tbl[0]  = v(H,H,b1,  L,L,z,  H,  L,L,L,z,  2'b00,16'd0,L);
        tbl[1]  = v(H,H,b1,  L,L,z,  H,  H,L,L,z,  2'b01,16'd0,H);
        tbl[2]  = v(H,H,b2,  L,L,z,  H,  H,L,H,b1, 2'b01,16'd1,H);
        tbl[3]  = v(H,H,b3,  L,L,z,  H,  H,L,H,b2, 2'b01,16'd2,H);
        tbl[4]  = v(H,H,b4,  L,L,z,  H,  H,L,H,b3, 2'b01,16'd3,H);
        tbl[5]  = v(L,L,z,   L,L,z,  H,  L,L,H,b4, 2'b01,16'd4,H);
        tbl[6]  = v(L,L,z,   L,L,z,  H,  L,L,L,b4, 2'b00,16'd4,L);
        // backpressure: ACK_I low for 3 cycles with a beat held
        tbl[7]  = v(H,H,da,  L,L,z,  H,  L,L,L,b4, 2'b00,16'd4,L);
        tbl[8]  = v(H,H,da,  L,L,z,  L,  H,L,L,b4, 2'b01,16'd0,H);
        tbl[9]  = v(H,H,db,  L,L,z,  L,  L,L,H,da, 2'b01,16'd1,H);
        tbl[10] = v(H,H,db,  L,L,z,  L,  L,L,H,da, 2'b01,16'd1,H);
        tbl[11] = v(H,H,db,  L,L,z,  L,  L,L,H,da, 2'b01,16'd1,H);
        tbl[12] = v(H,H,db,  L,L,z,  H,  H,L,H,da, 2'b01,16'd1,H);
        // CYC drop with buffered beat and ACK_I low -> DRAIN, S1 waits
        tbl[13] = v(L,L,z,   L,L,z,  L,  L,L,H,db, 2'b01,16'd2,H);
        tbl[14] = v(L,L,z,   H,H,dc, L,  L,L,H,db, 2'b00,16'd2,H);
        tbl[15] = v(L,L,z,   H,H,dc, L,  L,L,H,db, 2'b00,16'd2,H);
        tbl[16] = v(L,L,z,   H,H,dc, H,  L,L,H,db, 2'b00,16'd2,H);
        tbl[17] = v(L,L,z,   H,H,dc, H,  L,L,L,db, 2'b00,16'd2,L);
        tbl[18] = v(L,L,z,   H,H,dc, H,  L,H,L,db, 2'b10,16'd0,H);
        tbl[19] = v(L,L,z,   L,L,z,  H,  L,L,H,dc, 2'b10,16'd1,H);
        tbl[20] = v(L,L,z,   L,L,z,  H,  L,L,L,dc, 2'b00,16'd1,L);
        // tie with last grant = S1 -> S0 in both builds; S1 waits mid-frame
        tbl[21] = v(H,H,dd,  H,H,de, H,  L,L,L,dc, 2'b00,16'd1,L);
        tbl[22] = v(H,H,dd,  H,H,de, H,  H,L,L,dc, 2'b01,16'd0,H);
        tbl[23] = v(H,H,dd2, H,H,de, H,  H,L,H,dd, 2'b01,16'd1,H);
        tbl[24] = v(L,L,z,   H,H,de, H,  L,L,H,dd2,2'b01,16'd2,H);
        // repeated tie with last grant = S0: S1 round-robin, S0 fixed priority
        tbl[25] = v(H,H,dd3, H,H,de, H,  L,L,L,dd2,2'b00,16'd2,L);
        tbl[26] = v(H,H,dd3, H,H,de, H,  FIXED,~FIXED,L,dd2,g26,16'd0,H);
        tbl[27] = v(L,L,z,   L,L,z,  H,  L,L,H,w26,g26,16'd1,H);
        tbl[28] = v(L,L,z,   L,L,z,  H,  L,L,L,w26,2'b00,16'd1,L);

        // reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_we",  32'(we_o), 32'h0);
        chk("rst_stb", 32'(stb_o), 32'h0);
        chk("rst_cyc", 32'(cyc_o), 32'h0);
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_cnt", 32'(cnt_o), 32'h0);
        chk("rst_ack", 32'({s1_ack, s0_ack}), 32'h0);

        // directed table
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            s0_cyc = tbl[i].s0c; s0_stb = tbl[i].s0s; s0_dat = tbl[i].s0d; s0_we = 1'b1;
            s1_cyc = tbl[i].s1c; s1_stb = tbl[i].s1s; s1_dat = tbl[i].s1d; s1_we = 1'b0;
            ack_i  = tbl[i].ack;
            #1;
            chk($sformatf("row%0d_ack0", i), 32'(s0_ack), 32'(tbl[i].e_a0));
            chk($sformatf("row%0d_ack1", i), 32'(s1_ack), 32'(tbl[i].e_a1));
            chk($sformatf("row%0d_stb", i),  32'(stb_o),  32'(tbl[i].e_stb));
            chk($sformatf("row%0d_dat", i),  dat_o,       tbl[i].e_dat);
            chk($sformatf("row%0d_gnt", i),  32'(gnt_o),  32'(tbl[i].e_gnt));
            chk($sformatf("row%0d_cnt", i),  32'(cnt_o),  32'(tbl[i].e_cnt));
            chk($sformatf("row%0d_cyc", i),  32'(cyc_o),  32'(tbl[i].e_cyc));
        end

        // asynchronous reset mid-frame with a buffered beat, then first tie -> S0
        @(negedge clk);
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_dat = 32'h5A5A_0001; s0_we = 1'b1; ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("arst_pre_stb", 32'(stb_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_dat", dat_o, 32'h0);
        chk("arst_we",  32'(we_o), 32'h0);
        chk("arst_stb", 32'(stb_o), 32'h0);
        chk("arst_cyc", 32'(cyc_o), 32'h0);
        chk("arst_gnt", 32'(gnt_o), 32'h0);
        chk("arst_cnt", 32'(cnt_o), 32'h0);
        chk("arst_ack", 32'({s1_ack, s0_ack}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        s1_cyc = 1'b1; s1_stb = 1'b1; s1_dat = 32'h6B6B_0002;
        @(negedge clk);
        #1;
        chk("arst_tie_gnt",  32'(gnt_o), 32'h1);
        chk("arst_tie_ack0", 32'(s0_ack), 32'h1);
        chk("arst_tie_ack1", 32'(s1_ack), 32'h0);

        // long frame: beat counter saturates at all-ones
        do_reset();
        @(negedge clk);
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_dat = 32'h7FFF_8000; s0_we = 1'b1; ack_i = 1'b1;
        repeat (101) @(negedge clk);
        #1;
        chk("sat_cnt_100", 32'(cnt_o), 32'd100);
        repeat (69899) @(negedge clk);
        #1;
        chk("sat_cnt_ffff", 32'(cnt_o), 32'h0000_FFFF);
        chk("sat_gnt", 32'(gnt_o), 32'h1);
        s0_cyc = 1'b0; s0_stb = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("sat_cnt_hold", 32'(cnt_o), 32'h0000_FFFF);
        chk("sat_idle_cyc", 32'(cyc_o), 32'h0);

        // randomized traffic against the reference model
        do_reset();
        m_holder = -1; m_waiting = 1'b0; m_pend = {}; m_dat = 32'h0; m_we = 1'b0;
        m_cnt = 0; m_last = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit   rdy, ea0, ea1;
            logic [1:0] eg;
            logic [1:0] cv;
            @(negedge clk);
            if (s0_cyc) s0_cyc = ($urandom_range(0, 7) != 0);
            else        s0_cyc = ($urandom_range(0, 3) == 0);
            if (s1_cyc) s1_cyc = ($urandom_range(0, 7) != 0);
            else        s1_cyc = ($urandom_range(0, 3) == 0);
            s0_stb = ($urandom_range(0, 3) != 0);
            s1_stb = ($urandom_range(0, 3) != 0);
            s0_dat = $urandom; s1_dat = $urandom;
            s0_we  = 1'($urandom_range(0, 1)); s1_we = 1'($urandom_range(0, 1));
            ack_i  = ($urandom_range(0, 2) != 0);
            #1;
            cv  = {s1_cyc, s0_cyc};
            rdy = (m_pend.size() == 0) || ack_i;
            ea0 = (m_holder == 0) && s0_cyc && s0_stb && rdy;
            ea1 = (m_holder == 1) && s1_cyc && s1_stb && rdy;
            eg  = (m_holder == 0) ? 2'b01 : (m_holder == 1) ? 2'b10 : 2'b00;
            chk("rnd_ack0", 32'(s0_ack), 32'(ea0));
            chk("rnd_ack1", 32'(s1_ack), 32'(ea1));
            chk("rnd_stb",  32'(stb_o),  32'(m_pend.size() != 0));
            chk("rnd_dat",  dat_o,       m_dat);
            chk("rnd_we",   32'(we_o),   32'(m_we));
            chk("rnd_gnt",  32'(gnt_o),  32'(eg));
            chk("rnd_cyc",  32'(cyc_o),  32'((m_holder >= 0) || (m_pend.size() != 0)));
            chk("rnd_cnt",  32'(cnt_o),  32'(m_cnt));
            // advance the model across the coming clock edge
            if ((m_pend.size() != 0) && ack_i) m_pend = {};
            if (ea0 || ea1) begin
                m_dat = ea0 ? s0_dat : s1_dat;
                m_we  = ea0 ? s0_we  : s1_we;
                m_pend.push_back({m_we, m_dat});
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            if (m_holder >= 0) begin
                if (!cv[m_holder]) begin
                    m_holder  = -1;
                    m_waiting = (m_pend.size() != 0);
                end
            end else if (m_waiting) begin
                if (m_pend.size() == 0) m_waiting = 1'b0;
            end else if (cv != 2'b00) begin
                if (cv == 2'b11) m_holder = FIXED ? 0 : (1 - m_last);
                else             m_holder = cv[1] ? 1 : 0;
                m_last = m_holder;
                m_cnt  = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
